// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader and its neighbours.
package loader_pkg;

   localparam int LD_IM_ADDR_W = 8;
   localparam int LD_IM_DATA_W = 16;

   // A count byte of zero stands for a full 256-word image.
   localparam bit COUNT_ZERO_MEANS_256 = 1'b1;

   typedef enum logic [2:0] {
      S_COUNT = 3'd0,
      S_LO    = 3'd1,
      S_HI    = 3'd2,
      S_WRITE = 3'd3,
      S_CKSUM = 3'd4,
      S_RUN   = 3'd5,
      S_ERR   = 3'd6
   } loader_state_e;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-pair to instruction-word assembly with running XOR checksum.
module loader_word_asm
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        lo_we,
   input  logic        hi_we,
   input  logic [7:0]  byte_in,
   output logic [15:0] word,
   output logic [7:0]  acc
);

   logic [7:0] lo_q, lo_d;
   logic [7:0] acc_q, acc_d;

   // Capture the low byte and fold every data byte into the checksum.
   always_comb begin
      lo_d  = lo_q;
      acc_d = acc_q;
      if (clr) begin
         lo_d  = '0;
         acc_d = '0;
      end else if (lo_we) begin
         lo_d  = byte_in;
         acc_d = acc_q ^ byte_in;
      end else if (hi_we) begin
         acc_d = acc_q ^ byte_in;
      end
   end

   // Byte/accumulator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q  <= '0;
         acc_q <= '0;
      end else begin
         lo_q  <= lo_d;
         acc_q <= acc_d;
      end
   end

   // The high byte is taken straight from the bus so the word is ready on the HI transfer edge.
   assign word = {byte_in, lo_q};
   assign acc  = acc_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: count byte, word pairs into instruction memory, checksum, then CPU enable.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   S_COUNT | waiting for the word-count byte (0 = 256 words)
//   S_LO    | waiting for the low byte of the next word
//   S_HI    | waiting for the high byte of the next word
//   S_WRITE | one-cycle instruction-memory write, advance word count
//   S_CKSUM | waiting for the trailing XOR checksum byte
//   S_RUN   | image accepted, CPU enabled
//   S_ERR   | checksum mismatch, CPU held off
module program_loader
   import loader_pkg::*;
#(
   parameter int IM_ADDR_W   = LD_IM_ADDR_W,
   parameter int IM_DATA_W   = LD_IM_DATA_W,
   parameter bit CHECKSUM_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           byte_in,
   input  logic                 byte_valid,
   output logic                 byte_ready,
   input  logic                 reload,
   output logic                 im_we,
   output logic [IM_ADDR_W-1:0] im_addr,
   output logic [IM_DATA_W-1:0] im_data,
   output logic                 cpu_enable,
   output logic                 load_done,
   output logic                 load_error
);

   localparam int CNT_W = IM_ADDR_W + 1;

   loader_state_e        state_q, state_d;
   logic                 byte_ready_q, byte_ready_d;
   logic                 im_we_q, im_we_d;
   logic [IM_ADDR_W-1:0] im_addr_q, im_addr_d;
   logic [IM_DATA_W-1:0] im_data_q, im_data_d;
   logic                 cpu_enable_q, cpu_enable_d;
   logic                 load_done_q, load_done_d;
   logic                 load_error_q, load_error_d;
   logic [7:0]           n_q, n_d;
   logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;

   logic                 xfer;
   logic                 asm_clr, asm_lo_we, asm_hi_we;
   logic [15:0]          asm_word;
   logic [7:0]           asm_acc;
   logic [CNT_W-1:0]     n_total;
   logic [CNT_W-1:0]     word_cnt_inc;

   assign xfer         = byte_valid && byte_ready_q;
   assign n_total      = (n_q == 8'd0 && COUNT_ZERO_MEANS_256) ? CNT_W'(256) : CNT_W'(n_q);
   assign word_cnt_inc = word_cnt_q + CNT_W'(1);

   loader_word_asm u_word_asm (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (asm_clr),
      .lo_we   (asm_lo_we),
      .hi_we   (asm_hi_we),
      .byte_in (byte_in),
      .word    (asm_word),
      .acc     (asm_acc)
   );

   // Next-state and registered-output logic; reload overrides any pending transfer.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      word_cnt_d = word_cnt_q;
      im_addr_d  = im_addr_q;
      im_data_d  = im_data_q;
      asm_clr    = 1'b0;
      asm_lo_we  = 1'b0;
      asm_hi_we  = 1'b0;
      if (reload) begin
         state_d = S_COUNT;
      end else begin
         case (state_q)
            S_COUNT: begin
               if (xfer) begin
                  n_d        = byte_in;
                  word_cnt_d = '0;
                  im_addr_d  = '0;
                  asm_clr    = 1'b1;
                  state_d    = S_LO;
               end
            end
            S_LO: begin
               if (xfer) begin
                  asm_lo_we = 1'b1;
                  state_d   = S_HI;
               end
            end
            S_HI: begin
               if (xfer) begin
                  asm_hi_we = 1'b1;
                  im_data_d = IM_DATA_W'(asm_word);
                  im_addr_d = word_cnt_q[IM_ADDR_W-1:0];
                  state_d   = S_WRITE;
               end
            end
            S_WRITE: begin
               word_cnt_d = word_cnt_inc;
               if (word_cnt_inc == n_total) begin
                  state_d = CHECKSUM_EN ? S_CKSUM : S_RUN;
               end else begin
                  state_d = S_LO;
               end
            end
            S_CKSUM: begin
               if (xfer) begin
                  state_d = (byte_in == asm_acc) ? S_RUN : S_ERR;
               end
            end
            S_RUN, S_ERR: begin
               state_d = state_q;
            end
            default: begin
               state_d = S_COUNT;
            end
         endcase
      end
      byte_ready_d = (state_d == S_COUNT) || (state_d == S_LO) ||
                     (state_d == S_HI)    || (state_d == S_CKSUM);
      im_we_d      = (state_d == S_WRITE);
      cpu_enable_d = (state_d == S_RUN);
      load_done_d  = (state_d == S_RUN);
      load_error_d = (state_d == S_ERR);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_COUNT;
         byte_ready_q <= 1'b0;
         im_we_q      <= 1'b0;
         im_addr_q    <= '0;
         im_data_q    <= '0;
         cpu_enable_q <= 1'b0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         n_q          <= '0;
         word_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         byte_ready_q <= byte_ready_d;
         im_we_q      <= im_we_d;
         im_addr_q    <= im_addr_d;
         im_data_q    <= im_data_d;
         cpu_enable_q <= cpu_enable_d;
         load_done_q  <= load_done_d;
         load_error_q <= load_error_d;
         n_q          <= n_d;
         word_cnt_q   <= word_cnt_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign im_we      = im_we_q;
   assign im_addr    = im_addr_q;
   assign im_data    = im_data_q;
   assign cpu_enable = cpu_enable_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader with a byte-count based reference model.
module tb_program_loader;

   localparam bit CKEN = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        reload = 1'b0;
   logic        byte_ready, im_we, cpu_enable, load_done, load_error;
   logic [7:0]  im_addr;
   logic [15:0] im_data;

   int checks = 0;
   int errors = 0;

   program_loader #(.IM_ADDR_W(8), .IM_DATA_W(16), .CHECKSUM_EN(CKEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .reload     (reload),
      .im_we      (im_we),
      .im_addr    (im_addr),
      .im_data    (im_data),
      .cpu_enable (cpu_enable),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks how many stream bytes have been accepted since the load began.
   int          m_b = 0;
   int          m_n = 0;
   logic [7:0]  m_acc = 8'h00;
   logic [7:0]  m_lo = 8'h00;
   logic        m_nxt = 1'b0;
   logic        e_ready = 1'b0, e_we = 1'b0, e_done = 1'b0, e_err = 1'b0;
   logic [7:0]  e_addr = 8'h00;
   logic [15:0] e_data = 16'h0000;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_b = 0; m_n = 0; m_acc = 0; m_lo = 0;
         e_ready = 0; e_we = 0; e_addr = 0; e_data = 0; e_done = 0; e_err = 0;
      end else if (reload) begin
         m_b = 0; e_we = 0; e_done = 0; e_err = 0; e_ready = 1;
      end else begin
         m_nxt = 1'b0;
         if (e_we) begin
            if (m_b == 1 + 2 * m_n && !CKEN) e_done = 1'b1;
         end else if (byte_valid && e_ready) begin
            if (m_b == 0) begin
               m_n    = (byte_in == 8'd0) ? 256 : int'(byte_in);
               m_acc  = 8'h00;
               e_addr = 8'h00;
               m_b    = 1;
            end else if (m_b < 1 + 2 * m_n) begin
               m_acc = m_acc ^ byte_in;
               if (m_b % 2 == 1) begin
                  m_lo = byte_in;
               end else begin
                  e_data = {byte_in, m_lo};
                  e_addr = 8'((m_b - 2) / 2);
                  m_nxt  = 1'b1;
               end
               m_b++;
            end else begin
               if (byte_in == m_acc) e_done = 1'b1;
               else e_err = 1'b1;
            end
         end
         e_we    = m_nxt;
         e_ready = !e_we && !e_done && !e_err;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("byte_ready", 32'(byte_ready), 32'(e_ready));
         chk("im_we", 32'(im_we), 32'(e_we));
         chk("im_addr", 32'(im_addr), 32'(e_addr));
         chk("im_data", 32'(im_data), 32'(e_data));
         chk("cpu_enable", 32'(cpu_enable), 32'(e_done));
         chk("load_done", 32'(load_done), 32'(e_done));
         chk("load_error", 32'(load_error), 32'(e_err));
      end
   end

   // Memory image as written by the DUT, plus write log.
   logic [15:0] mem [256];
   logic [15:0] exp_mem [256];
   logic [7:0]  wa [$];
   logic [15:0] wd [$];

   always @(negedge clk) begin
      if (rst_n && im_we) begin
         wa.push_back(im_addr);
         wd.push_back(im_data);
         mem[im_addr] = im_data;
      end
   end

   // Present the queue under random back-pressure; returns cycles spent. Ends at a negedge with valid low.
   task automatic send_bytes(input logic [7:0] q[$], input int unsigned pct, output int cycles);
      int  i = 0;
      logic acc_now;
      cycles = 0;
      while (i < q.size() && cycles < 5000) begin
         @(negedge clk);
         byte_valid = ($urandom_range(99) < pct);
         byte_in    = byte_valid ? q[i] : 8'($urandom);
         acc_now    = byte_valid && byte_ready;
         @(posedge clk);
         cycles++;
         if (acc_now) i++;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      if (i < q.size()) chk("send_timeout", 32'(i), 32'(q.size()));
   endtask

   task automatic pulse_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   initial begin
      logic [7:0]  q[$];
      logic [7:0]  x;
      int          cyc, zeros, n, mism;
      for (int k = 0; k < 256; k++) begin mem[k] = 16'h0; exp_mem[k] = 16'h0; end

      // Power-on reset.
      #2 rst_n = 1'b0;
      #1;
      chk("por_ready", 32'(byte_ready), 32'h0);
      chk("por_cpu", 32'(cpu_enable), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(byte_ready), 32'h1);

      // Reset in the middle of a load (in the WRITE cycle of word 1).
      q = '{8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
      send_bytes(q, 100, cyc);
      chk("mid_we_before_rst", 32'(im_we), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(byte_ready), 32'h0);
      chk("rst_we", 32'(im_we), 32'h0);
      chk("rst_addr", 32'(im_addr), 32'h0);
      chk("rst_data", 32'(im_data), 32'h0);
      chk("rst_cpu", 32'(cpu_enable), 32'h0);
      chk("rst_done", 32'(load_done), 32'h0);
      chk("rst_err", 32'(load_error), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wa.delete(); wd.delete();
      q = '{8'h01, 8'h34, 8'h12, 8'h26};
      send_bytes(q, 100, cyc);
      chk("fresh_nwrites", 32'(wa.size()), 32'h1);
      if (wd.size() > 0) chk("fresh_word", 32'(wd[0]), 32'h1234);
      chk("fresh_cpu", 32'(cpu_enable), 32'h1);

      // Basic three-word load.
      pulse_reload();
      wa.delete(); wd.delete();
      q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      send_bytes(q, 100, cyc);
      chk("basic_done", 32'(load_done), 32'h1);
      chk("basic_cpu", 32'(cpu_enable), 32'h1);
      chk("basic_nwrites", 32'(wa.size()), 32'h3);
      if (wa.size() == 3) begin
         chk("basic_w0", 32'(wd[0]), 32'h2211);
         chk("basic_w1", 32'(wd[1]), 32'h4433);
         chk("basic_w2", 32'(wd[2]), 32'h6655);
         chk("basic_a2", 32'(wa[2]), 32'h2);
      end

      // Checksum error, then recovery by reload.
      pulse_reload();
      q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
      send_bytes(q, 100, cyc);
      chk("err_flag", 32'(load_error), 32'h1);
      chk("err_cpu", 32'(cpu_enable), 32'h0);
      pulse_reload();
      chk("err_cleared", 32'(load_error), 32'h0);
      chk("err_ready", 32'(byte_ready), 32'h1);

      // Full 256-word image, valid held high.
      wa.delete(); wd.delete();
      q = '{8'h00};
      x = 8'h00;
      for (int k = 0; k < 512; k++) begin q.push_back(8'(k)); x = x ^ 8'(k); end
      q.push_back(x);
      send_bytes(q, 100, cyc);
      chk("full_cycles", 32'(cyc), 32'd770);
      chk("full_nwrites", 32'(wa.size()), 32'd256);
      if (wa.size() == 256) chk("full_last_addr", 32'(wa[255]), 32'hFF);
      if (wd.size() == 256) chk("full_last_data", 32'(wd[255]), 32'hFFFE);
      zeros = 0;
      foreach (wa[k]) if (wa[k] == 8'h00) zeros++;
      chk("full_addr0_once", 32'(zeros), 32'h1);
      chk("full_done", 32'(load_done), 32'h1);

      // Random short loads under back-pressure; compare the whole memory image.
      for (int t = 0; t < 4; t++) begin
         pulse_reload();
         for (int k = 0; k < 256; k++) exp_mem[k] = mem[k];
         n = $urandom_range(20, 1);
         q = '{8'(n)};
         x = 8'h00;
         for (int k = 0; k < n; k++) begin
            logic [7:0] lo, hi;
            lo = 8'($urandom);
            hi = 8'($urandom);
            q.push_back(lo); q.push_back(hi);
            x = x ^ lo ^ hi;
            exp_mem[k] = {hi, lo};
         end
         q.push_back(x);
         send_bytes(q, $urandom_range(80, 30), cyc);
         mism = 0;
         for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) mism++;
         chk("rand_image_mismatches", 32'(mism), 32'h0);
         chk("rand_done", 32'(load_done), 32'h1);
      end

      // Reload while running drops the enable on that edge.
      chk("run_cpu_before", 32'(cpu_enable), 32'h1);
      pulse_reload();
      chk("run_reload_cpu", 32'(cpu_enable), 32'h0);
      chk("run_reload_ready", 32'(byte_ready), 32'h1);

      // Reload coincident with a valid high byte: byte discarded, restart from the count byte.
      q = '{8'h02, 8'hAA};
      send_bytes(q, 100, cyc);
      byte_valid = 1'b1;
      byte_in    = 8'hBB;
      reload     = 1'b1;
      @(negedge clk);
      reload     = 1'b0;
      byte_valid = 1'b0;
      chk("coinc_we", 32'(im_we), 32'h0);
      chk("coinc_ready", 32'(byte_ready), 32'h1);
      wa.delete(); wd.delete();
      q = '{8'h01, 8'hCD, 8'hAB, 8'h66};
      send_bytes(q, 60, cyc);
      chk("coinc_nwrites", 32'(wa.size()), 32'h1);
      if (wa.size() == 1) begin
         chk("coinc_addr", 32'(wa[0]), 32'h0);
         chk("coinc_word", 32'(wd[0]), 32'hABCD);
      end
      chk("coinc_done", 32'(load_done), 32'h1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
